vector_out_port: RTL
====================

Name: vector_out_port

Overview:
- Producer end of the CPU output stream `out`/`outFlag`; the external image dump consumes this stream.
- Accepts writeback-stage vector stores (VECTOR_SIZE lanes of DATA_WIDTH), converts each lane to an OUTPUT_WIDTH pixel, and buffers packed words in a small FIFO.
- Emits one word per `outFlag` pulse, with a configurable minimum gap between pulses.
- Asserts `stall` to the pipeline when the buffer is full.

Parameters:
- DATA_WIDTH, 19, lane width of incoming vector data (two's complement).
- VECTOR_SIZE, 6, number of lanes.
- OUTPUT_WIDTH, 8, output pixel width per lane (unsigned).
- FIFO_DEPTH, 4, buffered packed words; must be a power of 2, ≥2.
- OUT_GAP, 0, idle cycles forced after each `outFlag` pulse (0 = one word per cycle).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- outEnable  in  1  vector store request from writeback.
- vectorIn  in  VECTOR_SIZE*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- saturate  in  1  1 = clamp lanes to [0, 2^OUTPUT_WIDTH-1]; 0 = keep low OUTPUT_WIDTH bits.
- stall  out  1  buffer full; pipeline must hold the store.
- out  out  VECTOR_SIZE*OUTPUT_WIDTH  packed pixels; lane i at bits [i*OUTPUT_WIDTH +: OUTPUT_WIDTH].
- outFlag  out  1  single-cycle valid pulse for `out`.
- wordsOut  out  32  running count of emitted words.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO pointers, count and gap counter cleared.
  - `out`=0, `outFlag`=0, `wordsOut`=0, `stall`=0.
  - Reset mid-stream discards all pending words; no partial word is ever emitted.
- Lane conversion (combinational, before FIFO write):
  - saturate=1: negative → 0; above 2^OUTPUT_WIDTH-1 → 2^OUTPUT_WIDTH-1; otherwise the value unchanged.
  - saturate=0: vectorIn lane[OUTPUT_WIDTH-1:0].
  - `saturate` is sampled together with `vectorIn`, per word.
- Write:
  - At a rising edge, if outEnable=1 and count<FIFO_DEPTH, the converted word is stored at wrPtr, and wrPtr increments modulo FIFO_DEPTH.
  - If outEnable=1 while count==FIFO_DEPTH, the write is ignored; the pipeline is responsible for holding it under `stall`.
- stall: combinational, equal to (count==FIFO_DEPTH) from the registered count. It stays asserted during a full-cycle pop; this is conservative and is the intended behaviour.
- Emit: at a rising edge, if count>0 and gapCnt==0:
  - `out` ← mem[rdPtr], `outFlag` ← 1.
  - rdPtr increments modulo FIFO_DEPTH.
  - gapCnt ← OUT_GAP.
  - `wordsOut` increments, wrapping at 2^32.
- Otherwise at a rising edge:
  - `outFlag` ← 0 and `out` holds its last value.
  - gapCnt decrements if nonzero.
- Latency: a word written at edge k into an empty FIFO with gapCnt=0 appears with outFlag=1 after edge k+1. There is no same-cycle bypass.
- Simultaneous write and emit in one edge: count is unchanged; both pointers advance.
- Throughput: with OUT_GAP=G, consecutive `outFlag` pulses are exactly G+1 cycles apart while data is pending.
- Ordering: strictly FIFO; no word is duplicated or dropped once accepted.
- `outFlag` is never high for two consecutive cycles when OUT_GAP>0.

Decomposition:
- Package cpu_out_pkg holds:
  - DATA_WIDTH, VECTOR_SIZE, OUTPUT_WIDTH defaults.
  - Typedefs `lane_t` (signed DATA_WIDTH) and `pixel_t` (OUTPUT_WIDTH).
  - Typedef `out_word_t` (VECTOR_SIZE*OUTPUT_WIDTH).
- Sub-module lane_clamp: purely combinational, one `lane_t` plus `saturate` to one `pixel_t`, instantiated VECTOR_SIZE times via generate.
- FIFO storage, pointers, count and gap counter stay in vector_out_port.

Test Plan:
- Convert, saturate=1: lanes 0..5 = -5, 300, 255, 0, 128, 1 → one outFlag pulse two edges after the write; out = 48'h0180_00FF_FF00.
- Convert, saturate=0: same lanes → out = 48'h0180_00FF_2CFB (-5 → FB, 300 → 2C).
- Burst with OUT_GAP=0, FIFO_DEPTH=4: 6 back-to-back writes → stall never asserts; 6 consecutive outFlag pulses in order; wordsOut=6.
- Full and gapped, OUT_GAP=3: 6 back-to-back writes.
  - stall asserts once count reaches 4.
  - Words presented during stall are dropped unless the bench holds them; with the bench holding, all 6 arrive in order.
  - Pulses are spaced exactly 4 cycles apart.
- Reset mid-operation: assert reset with 3 words pending → outFlag drops immediately; out=0, wordsOut=0; no further pulses after release until a new write occurs.
- Simultaneous write+emit at count=FIFO_DEPTH-1: count stays constant, stall stays 0, order preserved across pointer wrap-around (≥10 words streamed).

Source files
------------

// File: rtl/cpu_out_pkg.sv
// cpu_out_pkg: shared widths and types for the CPU output stream producer.
package cpu_out_pkg;
  localparam int DATA_WIDTH   = 19;
  localparam int VECTOR_SIZE  = 6;
  localparam int OUTPUT_WIDTH = 8;
  typedef logic signed [DATA_WIDTH-1:0]           lane_t;
  typedef logic [OUTPUT_WIDTH-1:0]                pixel_t;
  typedef logic [VECTOR_SIZE*OUTPUT_WIDTH-1:0]    out_word_t;
endpackage

// File: rtl/lane_clamp.sv
// lane_clamp: converts one signed lane to an unsigned pixel, clamped or truncated.
module lane_clamp
  import cpu_out_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int OW = OUTPUT_WIDTH
) (
  input  logic signed [DW-1:0] lane,
  input  logic                 saturate,
  output logic [OW-1:0]        pixel
);
  // Non-negative lanes exceed the pixel range iff any bit above the pixel width is set.
  always_comb
    pixel = !saturate        ? lane[OW-1:0] :
            lane[DW-1]       ? '0 :
            |lane[DW-2:OW]   ? '1 :
                               lane[OW-1:0];
endmodule

// File: rtl/vector_out_port.sv
// vector_out_port: buffers converted vector stores and emits one packed word per outFlag pulse.
module vector_out_port #(
  parameter int DATA_WIDTH   = cpu_out_pkg::DATA_WIDTH,
  parameter int VECTOR_SIZE  = cpu_out_pkg::VECTOR_SIZE,
  parameter int OUTPUT_WIDTH = cpu_out_pkg::OUTPUT_WIDTH,
  parameter int FIFO_DEPTH   = 4,
  parameter int OUT_GAP      = 0
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                outEnable,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0]   vectorIn,
  input  logic                                saturate,
  output logic                                stall,
  output logic [VECTOR_SIZE*OUTPUT_WIDTH-1:0] out,
  output logic                                outFlag,
  output logic [31:0]                         wordsOut
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = OUT_GAP > 0 ? $clog2(OUT_GAP + 1) : 1;
  localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP  = GW'(OUT_GAP);
  logic [VECTOR_SIZE*OUTPUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [VECTOR_SIZE*OUTPUT_WIDTH-1:0] conv;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [GW-1:0] gap_cnt;
  logic          wr, rd;
  genvar i;
  for (i = 0; i < VECTOR_SIZE; i++) begin : g_lane
    lane_clamp #(.DW(DATA_WIDTH), .OW(OUTPUT_WIDTH)) u_clamp (
      .lane     (vectorIn[i*DATA_WIDTH +: DATA_WIDTH]),
      .saturate (saturate),
      .pixel    (conv[i*OUTPUT_WIDTH +: OUTPUT_WIDTH])
    );
  end
  always_comb begin
    stall = count == FULL;
    wr    = outEnable && !stall;
    rd    = count != '0 && gap_cnt == '0;
  end
  always_ff @(posedge clock)
    if (wr) mem[wr_ptr] <= conv;
  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      gap_cnt  <= '0;
      out      <= '0;
      outFlag  <= 1'b0;
      wordsOut <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) begin
        rd_ptr   <= rd_ptr + 1'b1;
        out      <= mem[rd_ptr];
        gap_cnt  <= GAP;
        wordsOut <= wordsOut + 32'd1;
      end else if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
      outFlag <= rd;
      count   <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule
